// File: rtl/blake2b_msg_feeder_if.sv
// Stream-in / compressor-out bus of the BLAKE2b message feeder.
// master = feeder side, slave = host stream source plus compressor.
interface blake2b_msg_feeder_if;
  logic          s_valid;
  logic          s_ready;
  logic [63:0]   s_data;
  logic          s_last;
  logic [3:0]    s_bytes;
  logic          cmp_start;
  logic [511:0]  cmp_h;
  logic [1023:0] cmp_m;
  logic [127:0]  cmp_t;
  logic [127:0]  cmp_f;
  logic          cmp_done;
  logic [511:0]  cmp_h_o;
  logic          digest_valid;
  logic [511:0]  digest;

  modport master (
    input  s_valid, s_data, s_last, s_bytes, cmp_done, cmp_h_o,
    output s_ready, cmp_start, cmp_h, cmp_m, cmp_t, cmp_f, digest_valid, digest
  );

  modport slave (
    output s_valid, s_data, s_last, s_bytes, cmp_done, cmp_h_o,
    input  s_ready, cmp_start, cmp_h, cmp_m, cmp_t, cmp_f, digest_valid, digest
  );
endinterface

// File: rtl/blake2b_msg_feeder.sv
// Packs a 64-bit little-endian word stream into 128-byte BLAKE2b blocks,
// drives the compressor with h/m/t/f and chains its result until the digest.
module blake2b_msg_feeder #(
  parameter int NN = 64,
  parameter int KK = 0
) (
  input  logic               clk,
  input  logic               rst,
  blake2b_msg_feeder_if.master bus
);

  localparam logic [63:0] H0 = 64'h6a09e667f3bcc908 ^ 64'h0000_0000_0101_0000
                             ^ (64'(KK) << 8) ^ 64'(NN);
  localparam logic [7:0][63:0] IV = {
    64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b,
    64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
    64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b,
    64'hbb67ae8584caa73b, H0
  };

  typedef enum logic [2:0] {INIT, FILL, HOLD, COMP_N, COMP_F, WAIT} state_t;

  state_t            state, state_nxt;
  logic [7:0][63:0]  h;
  logic [15:0][63:0] m;
  logic [127:0]      t;
  logic              f_last;
  logic [4:0]        idx;
  logic [511:0]      digest_r;
  logic              digest_valid_r;
  logic              s_ready_c, cmp_start_c, hs;
  logic [3:0]        nb;
  logic [63:0]       word_in;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT: state_nxt = FILL;
      FILL: begin
        if (hs) begin
          if (bus.s_last)        state_nxt = COMP_F;
          else if (idx == 5'd15) state_nxt = HOLD;
        end
      end
      // Block is full: wait for evidence of more data before declaring it non-final.
      HOLD:           if (bus.s_valid) state_nxt = COMP_N;
      COMP_N, COMP_F: state_nxt = WAIT;
      WAIT:           if (bus.cmp_done) state_nxt = f_last ? INIT : FILL;
      default:        state_nxt = INIT;
    endcase
  end

  always_comb begin
    s_ready_c   = (state == FILL);
    cmp_start_c = (state == COMP_N) || (state == COMP_F);
  end

  assign hs = bus.s_valid && s_ready_c;

  // Zero s_bytes means 8 except for an empty message; nothing has been counted yet iff t==0.
  always_comb begin
    if (bus.s_bytes == 4'd0)     nb = (t == '0) ? 4'd0 : 4'd8;
    else if (bus.s_bytes > 4'd8) nb = 4'd8;
    else                         nb = bus.s_bytes;
    word_in = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (!bus.s_last || b < 32'(nb)) word_in[8*b +: 8] = bus.s_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h              <= IV;
      m              <= '0;
      t              <= '0;
      f_last         <= 1'b0;
      idx            <= '0;
      digest_r       <= '0;
      digest_valid_r <= 1'b0;
    end else begin
      digest_valid_r <= 1'b0;
      case (state)
        INIT: begin
          h      <= IV;
          m      <= '0;
          t      <= '0;
          f_last <= 1'b0;
          idx    <= '0;
        end
        FILL: begin
          if (hs) begin
            idx <= idx + 5'd1;
            if (bus.s_last) begin
              t      <= t + 128'(nb);
              f_last <= 1'b1;
              for (int unsigned w = 0; w < 16; w++) begin
                if (w > 32'(idx)) m[w[3:0]] <= '0;
              end
            end else begin
              t <= t + 128'd8;
            end
            m[idx[3:0]] <= word_in;
          end
        end
        WAIT: begin
          if (bus.cmp_done) begin
            h <= bus.cmp_h_o;
            if (f_last) begin
              digest_r       <= bus.cmp_h_o;
              digest_valid_r <= 1'b1;
            end else begin
              m   <= '0;
              idx <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready      = s_ready_c;
  assign bus.cmp_start    = cmp_start_c;
  assign bus.cmp_h        = h;
  assign bus.cmp_m        = m;
  assign bus.cmp_t        = t;
  assign bus.cmp_f        = {64'd0, {64{f_last}}};
  assign bus.digest_valid = digest_valid_r;
  assign bus.digest       = digest_r;

endmodule

// File: tb/tb_blake2b_msg_feeder.sv
// Bench for blake2b_msg_feeder: random byte messages, a byte-level block model
// and a compressor stub returning random chaining values.
module tb_blake2b_msg_feeder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blake2b_msg_feeder_if bus ();

  blake2b_msg_feeder #(.NN(64), .KK(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned      msg [0:1023];
  int                msg_len;
  logic [7:0][63:0]  iv;
  logic [63:0]       cap_h0, cap_m0;
  logic [127:0]      cap_t, cap_f;
  int                cap_blocks;

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: blocks are 128-byte slices of the message, zero padded.
  function automatic int model_nblocks();
    return (msg_len == 0) ? 1 : (msg_len + 127) / 128;
  endfunction

  function automatic logic [1023:0] model_m(input int k);
    logic [1023:0] r = '0;
    for (int j = 0; j < 128; j++) begin
      if (128*k + j < msg_len) r[8*j +: 8] = msg[128*k + j];
    end
    return r;
  endfunction

  function automatic logic [127:0] model_t(input int k);
    int lim = 128 * (k + 1);
    return 128'((msg_len < lim) ? msg_len : lim);
  endfunction

  task automatic send_words(input int gap_max);
    int nw = (msg_len == 0) ? 1 : (msg_len + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      logic [63:0] data;
      logic [3:0]  sb;
      int rem, waited;
      bus.s_valid = 1'b0;
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      for (int b = 0; b < 8; b++)
        data[8*b +: 8] = (8*w + b < msg_len) ? msg[8*w + b] : 8'($urandom);
      rem = msg_len - 8*w;
      if (w != nw - 1)      sb = 4'($urandom);
      else if (rem != 8)    sb = 4'(rem);
      else begin
        case ($urandom_range(2, 0))
          0:       sb = 4'd8;
          1:       sb = (w > 0) ? 4'd0 : 4'd8;
          default: sb = 4'($urandom_range(15, 9));
        endcase
      end
      bus.s_data  = data;
      bus.s_bytes = sb;
      bus.s_last  = (w == nw - 1);
      bus.s_valid = 1'b1;
      if (w > 0 && w % 16 == 0) check_val("hold_ready", 512'(bus.s_ready), 512'(0));
      waited = 0;
      while (!bus.s_ready) begin
        @(negedge clk);
        waited++;
        if (waited > 3000) begin
          check_val("ready_timeout", 512'(0), 512'(1));
          bus.s_valid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic stub(input int dmin, input int dmax);
    int nbk = model_nblocks();
    logic [511:0] prev_ho = '0;
    cap_blocks = 0;
    for (int k = 0; k < nbk; k++) begin
      logic [511:0]  exp_h, ho;
      logic [1023:0] exp_m;
      logic [127:0]  exp_t, exp_f;
      int cnt = 0;
      int d;
      while (!bus.cmp_start) begin
        @(negedge clk);
        cnt++;
        if (cnt > 5000) begin
          check_val("start_timeout", 512'(0), 512'(1));
          return;
        end
      end
      cap_blocks++;
      if (k == 0) begin
        cap_h0 = bus.cmp_h[63:0];
        cap_m0 = bus.cmp_m[63:0];
        cap_t  = bus.cmp_t;
        cap_f  = bus.cmp_f;
      end
      exp_h = (k == 0) ? iv : prev_ho;
      exp_m = model_m(k);
      exp_t = model_t(k);
      exp_f = (k == nbk - 1) ? {64'd0, {64{1'b1}}} : '0;
      check_val("blk_h", bus.cmp_h, exp_h);
      check_val("blk_m_lo", bus.cmp_m[511:0], exp_m[511:0]);
      check_val("blk_m_hi", bus.cmp_m[1023:512], exp_m[1023:512]);
      check_val("blk_t", 512'(bus.cmp_t), 512'(exp_t));
      check_val("blk_f", 512'(bus.cmp_f), 512'(exp_f));
      d = $urandom_range(dmax, dmin);
      for (int i = 0; i <= d; i++) begin
        @(negedge clk);
        check_val("wait_start", 512'(bus.cmp_start), 512'(0));
        check_val("wait_ready", 512'(bus.s_ready), 512'(0));
        check_val("wait_h", bus.cmp_h, exp_h);
        check_val("wait_m", 512'(bus.cmp_m[1023:512] ^ bus.cmp_m[511:0]),
                  512'(exp_m[1023:512] ^ exp_m[511:0]));
        check_val("wait_t", 512'(bus.cmp_t), 512'(exp_t));
        check_val("wait_f", 512'(bus.cmp_f), 512'(exp_f));
      end
      for (int i = 0; i < 16; i++) ho[32*i +: 32] = $urandom;
      bus.cmp_h_o  = ho;
      bus.cmp_done = 1'b1;
      @(negedge clk);
      bus.cmp_done = 1'b0;
      bus.cmp_h_o  = {16{32'hdead_beef}};
      prev_ho = ho;
      if (k == nbk - 1) begin
        check_val("digest_valid", 512'(bus.digest_valid), 512'(1));
        check_val("digest", bus.digest, ho);
        @(negedge clk);
        check_val("digest_pulse", 512'(bus.digest_valid), 512'(0));
      end
    end
  endtask

  task automatic run_msg(input int gap_max, input int dmin, input int dmax);
    fork
      send_words(gap_max);
      stub(dmin, dmax);
    join
    repeat (4) begin
      @(negedge clk);
      check_val("no_extra_start", 512'(bus.cmp_start), 512'(0));
    end
  endtask

  task automatic set_random_msg(input int len);
    msg_len = len;
    for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
  endtask

  task automatic set_abc();
    msg_len = 3;
    msg[0] = 8'h61;
    msg[1] = 8'h62;
    msg[2] = 8'h63;
  endtask

  task automatic check_abc_block();
    check_val("abc_blocks", 512'(cap_blocks), 512'(1));
    check_val("abc_h0", 512'(cap_h0), 512'(64'h6A09E667F2BDC948));
    check_val("abc_m0", 512'(cap_m0), 512'(64'h0000000000636261));
    check_val("abc_t", 512'(cap_t), 512'(3));
    check_val("abc_f", 512'(cap_f), 512'({64'd0, 64'hFFFF_FFFF_FFFF_FFFF}));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iv[0] = 64'h6a09e667f3bcc908 ^ 64'h0101_0000 ^ 64'd64;
    iv[1] = 64'hbb67ae8584caa73b;
    iv[2] = 64'h3c6ef372fe94f82b;
    iv[3] = 64'ha54ff53a5f1d36f1;
    iv[4] = 64'h510e527fade682d1;
    iv[5] = 64'h9b05688c2b3e6c1f;
    iv[6] = 64'h1f83d9abfb41bd6b;
    iv[7] = 64'h5be0cd19137e2179;

    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.s_bytes = '0;
    bus.cmp_done = 1'b0; bus.cmp_h_o = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_ready", 512'(bus.s_ready), 512'(0));
    check_val("rst_start", 512'(bus.cmp_start), 512'(0));
    check_val("rst_m_lo", bus.cmp_m[511:0], 512'(0));
    check_val("rst_m_hi", bus.cmp_m[1023:512], 512'(0));
    check_val("rst_t", 512'(bus.cmp_t), 512'(0));
    check_val("rst_f", 512'(bus.cmp_f), 512'(0));
    check_val("rst_dvalid", 512'(bus.digest_valid), 512'(0));
    check_val("rst_digest", bus.digest, 512'(0));
    check_val("rst_h", bus.cmp_h, iv);
    rst = 1'b0;
    @(negedge clk);

    set_abc();              run_msg(2, 0, 3); check_abc_block();
    set_random_msg(0);      run_msg(2, 0, 3);
    check_val("empty_blocks", 512'(cap_blocks), 512'(1));
    check_val("empty_t", 512'(cap_t), 512'(0));
    set_random_msg(128);    run_msg(2, 0, 3);
    check_val("b128_blocks", 512'(cap_blocks), 512'(1));
    set_random_msg(136);    run_msg(2, 0, 3);
    check_val("b136_blocks", 512'(cap_blocks), 512'(2));
    set_random_msg(200);    run_msg(1, 40, 40);

    // Reset while the compressor is busy, then a stale done.
    set_abc();
    bus.s_data = 64'h0000000000636261; bus.s_last = 1'b1; bus.s_bytes = 4'd3;
    bus.s_valid = 1'b1;
    begin
      int cnt = 0;
      while (!bus.s_ready && cnt < 100) begin @(negedge clk); cnt++; end
      check_val("rtest_ready", 512'(bus.s_ready), 512'(1));
    end
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    check_val("rtest_start", 512'(bus.cmp_start), 512'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rtest_f", 512'(bus.cmp_f), 512'(0));
    @(negedge clk);
    bus.cmp_h_o  = {16{32'h1234_5678}};
    bus.cmp_done = 1'b1;
    @(negedge clk);
    bus.cmp_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_val("rtest_no_digest", 512'(bus.digest_valid), 512'(0));
    end
    check_val("rtest_h", bus.cmp_h, iv);
    check_val("rtest_digest", bus.digest, 512'(0));
    set_abc();              run_msg(2, 0, 3); check_abc_block();

    for (int i = 0; i < 10; i++) begin
      set_random_msg($urandom_range(600, 0));
      run_msg(3, 0, 6);
    end
    set_random_msg(256);    run_msg(0, 0, 0);
    set_random_msg(1000);   run_msg(2, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
